// File: rtl/gt_set_assoc_cache.sv
// -----------------------------------------------------------------------------
// gt_set_assoc_cache
//   N-way set-associative read cache with true-LRU replacement. A byte read is
//   accepted over a valid/ready port and answered with the byte and a hit flag.
//   On a miss the whole line is fetched from memory, written into the victim
//   way, and a valid victim line is pushed out toward the victim cache.
//
// Ports
//   CLK, RST        clock (rising edge), synchronous active-high reset
//   req_valid       read request, accepted on an edge where req_ready is high
//   req_addr        byte address of the read
//   req_ready       high only while the cache is idle
//   resp_valid      one-cycle response pulse
//   hit             1 = served from cache, 0 = served by a fill (held)
//   dataReturn      requested byte (held until the next response)
//   mem_req_valid   line fetch request, held until memory answers
//   mem_req_addr    line-aligned fetch address
//   mem_resp_valid  memData valid; only looked at while waiting on memory
//   memData         fill line, byte i = memData[8i+7:8i]
//   evict_valid     one-cycle pulse: a valid line was replaced
//   evict_addr      line-aligned address of the replaced line
//   toMemData       contents of the replaced line (held until next eviction)
//   stateDbg        current FSM state, for debug and checkers
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; req_valid while req_ready is low is ignored and
// never queued. The memory side is request/acknowledge: mem_req_valid stays
// high until an edge with mem_resp_valid high, which completes the fetch.
// -----------------------------------------------------------------------------
module gt_set_assoc_cache #(
   parameter int ADDR_W     = 32,
   parameter int LINE_BYTES = 32,
   parameter int SETS       = 8,
   parameter int WAYS       = 2
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    req_valid,
   input  logic [ADDR_W-1:0]       req_addr,
   output logic                    req_ready,
   output logic                    resp_valid,
   output logic                    hit,
   output logic [7:0]              dataReturn,
   output logic                    mem_req_valid,
   output logic [ADDR_W-1:0]       mem_req_addr,
   input  logic                    mem_resp_valid,
   input  logic [LINE_BYTES*8-1:0] memData,
   output logic                    evict_valid,
   output logic [ADDR_W-1:0]       evict_addr,
   output logic [LINE_BYTES*8-1:0] toMemData,
   output logic [1:0]              stateDbg
);

   localparam int OFF_W  = $clog2(LINE_BYTES);
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
   localparam int AGE_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int LINE_W = LINE_BYTES * 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      MISS   = 2'd2,
      FILL   = 2'd3
   } stateT;

   stateT state;

   logic [ADDR_W-1:0] addrQ;
   logic [LINE_W-1:0] fillLine;

   logic [LINE_W-1:0] dataArr  [SETS][WAYS];
   logic [TAG_W-1:0]  tagArr   [SETS][WAYS];
   logic [WAYS-1:0]   validArr [SETS];
   logic [AGE_W-1:0]  ageArr   [SETS][WAYS];

   logic [OFF_W-1:0] off;
   logic [IDX_W-1:0] idx;
   logic [TAG_W-1:0] tag;

   assign off = addrQ[OFF_W-1:0];
   assign idx = addrQ[OFF_W +: IDX_W];
   assign tag = addrQ[ADDR_W-1 -: TAG_W];

   assign stateDbg = state;

   // Tag compare across every way of the addressed set.
   logic             hitFound;
   logic [AGE_W-1:0] hitWay;

   always_comb begin
      hitFound = 1'b0;
      hitWay   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!hitFound && validArr[idx][w] && (tagArr[idx][w] == tag)) begin
            hitFound = 1'b1;
            hitWay   = AGE_W'(w);
         end
      end
   end

   // Victim: lowest-index invalid way first, else the oldest way. Ages are a
   // permutation of 0..WAYS-1, so exactly one way carries age WAYS-1.
   logic             invFound;
   logic [AGE_W-1:0] victimWay;

   always_comb begin
      invFound  = 1'b0;
      victimWay = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (!invFound && !validArr[idx][w]) begin
            invFound  = 1'b1;
            victimWay = AGE_W'(w);
         end
      end
      if (!invFound) begin
         for (int w = 0; w < WAYS; w++) begin
            if (ageArr[idx][w] == AGE_W'(WAYS - 1)) begin
               victimWay = AGE_W'(w);
            end
         end
      end
   end

   // Age update for the way being touched: it becomes youngest and every way
   // that was younger than it moves one step older.
   logic [AGE_W-1:0] accWay;
   logic [AGE_W-1:0] newAge [WAYS];

   always_comb begin
      accWay = (state == LOOKUP) ? hitWay : victimWay;
      for (int w = 0; w < WAYS; w++) begin
         newAge[w] = ageArr[idx][w];
         if (AGE_W'(w) == accWay) begin
            newAge[w] = '0;
         end else if (ageArr[idx][w] < ageArr[idx][accWay]) begin
            newAge[w] = ageArr[idx][w] + 1'b1;
         end
      end
   end

   logic [7:0] hitByte;
   logic [7:0] fillByte;

   assign hitByte  = dataArr[idx][hitWay][{off, 3'b000} +: 8];
   assign fillByte = fillLine[{off, 3'b000} +: 8];

   // Line storage carries no reset; validity is tracked separately.
   always_ff @(posedge CLK) begin
      if (!RST && state == FILL) begin
         dataArr[idx][victimWay] <= fillLine;
         tagArr[idx][victimWay]  <= tag;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= IDLE;
         addrQ         <= '0;
         fillLine      <= '0;
         req_ready     <= 1'b1;
         resp_valid    <= 1'b0;
         hit           <= 1'b0;
         dataReturn    <= '0;
         mem_req_valid <= 1'b0;
         mem_req_addr  <= '0;
         evict_valid   <= 1'b0;
         evict_addr    <= '0;
         toMemData     <= '0;
         for (int s = 0; s < SETS; s++) begin
            validArr[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               ageArr[s][w] <= AGE_W'(w);
            end
         end
      end else begin
         resp_valid  <= 1'b0;
         evict_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  addrQ     <= req_addr;
                  req_ready <= 1'b0;
                  state     <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (hitFound) begin
                  resp_valid <= 1'b1;
                  hit        <= 1'b1;
                  dataReturn <= hitByte;
                  for (int w = 0; w < WAYS; w++) begin
                     ageArr[idx][w] <= newAge[w];
                  end
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end else begin
                  mem_req_valid <= 1'b1;
                  mem_req_addr  <= {tag, idx, {OFF_W{1'b0}}};
                  state         <= MISS;
               end
            end
            MISS: begin
               if (mem_resp_valid) begin
                  fillLine      <= memData;
                  mem_req_valid <= 1'b0;
                  state         <= FILL;
               end
            end
            FILL: begin
               if (validArr[idx][victimWay]) begin
                  evict_valid <= 1'b1;
                  evict_addr  <= {tagArr[idx][victimWay], idx, {OFF_W{1'b0}}};
                  toMemData   <= dataArr[idx][victimWay];
               end
               validArr[idx][victimWay] <= 1'b1;
               for (int w = 0; w < WAYS; w++) begin
                  ageArr[idx][w] <= newAge[w];
               end
               resp_valid <= 1'b1;
               hit        <= 1'b0;
               dataReturn <= fillByte;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gt_set_assoc_cache.sv
// -----------------------------------------------------------------------------
// tb_gt_set_assoc_cache
//   Directed scenarios followed by randomized reads. A reference model (per-set
//   valid/tag/line plus recency timestamps) predicts every response, eviction
//   and line fetch at the moment a request is accepted; a monitor pops those
//   predictions whenever the cache presents the matching output.
// -----------------------------------------------------------------------------
module tb_gt_set_assoc_cache;

   localparam int ADDR_W     = 32;
   localparam int LINE_BYTES = 32;
   localparam int SETS       = 8;
   localparam int WAYS       = 2;
   localparam int LINE_W     = LINE_BYTES * 8;
   localparam int TAG_W      = ADDR_W - 3 - 5;
   localparam int CMP_W      = LINE_W + ADDR_W;

   // ---------------- clock / reset and DUT ----------------
   logic                CLK = 1'b0;
   logic                RST = 1'b1;
   logic                req_valid = 1'b0;
   logic [ADDR_W-1:0]   req_addr = '0;
   logic                req_ready;
   logic                resp_valid;
   logic                hit;
   logic [7:0]          dataReturn;
   logic                mem_req_valid;
   logic [ADDR_W-1:0]   mem_req_addr;
   logic                mem_resp_valid = 1'b0;
   logic [LINE_W-1:0]   memData = '0;
   logic                evict_valid;
   logic [ADDR_W-1:0]   evict_addr;
   logic [LINE_W-1:0]   toMemData;
   logic [1:0]          stateDbg;

   always #5 CLK = ~CLK;

   gt_set_assoc_cache #(
      .ADDR_W(ADDR_W), .LINE_BYTES(LINE_BYTES), .SETS(SETS), .WAYS(WAYS)
   ) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .resp_valid(resp_valid), .hit(hit), .dataReturn(dataReturn),
      .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr),
      .mem_resp_valid(mem_resp_valid), .memData(memData),
      .evict_valid(evict_valid), .evict_addr(evict_addr), .toMemData(toMemData),
      .stateDbg(stateDbg)
   );

   // ---------------- counters and scoreboard queues ----------------
   int nVec  = 0;
   int nFail = 0;

   logic [8:0]              expQ[$];     // {hit, byte}
   logic [CMP_W-1:0]        evictQ[$];   // {line address, line data}
   logic [ADDR_W-1:0]       memReqQ[$];  // expected fetch addresses

   int               respCount   = 0;
   int               evictCount  = 0;
   int               memReqCount = 0;
   logic [ADDR_W-1:0] lastMemReqAddr = '0;
   logic              prevMemReq = 1'b0;

   task automatic check(input string name, input logic [CMP_W-1:0] act,
                        input logic [CMP_W-1:0] exp);
      nVec++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // ---------------- memory contents ----------------
   logic              genMode   = 1'b0;
   logic [LINE_W-1:0] fixedLine = '0;
   logic [LINE_W-1:0] pattern;
   logic              memHold   = 1'b0;

   function automatic logic [LINE_W-1:0] memLine(input logic [ADDR_W-1:0] a);
      logic [LINE_W-1:0] l;
      l = fixedLine;
      if (genMode) begin
         for (int i = 0; i < LINE_BYTES; i++) begin
            l[8*i +: 8] = 8'(int'(a[23:5]) * 7 + i * 13 + 5);
         end
      end
      return l;
   endfunction

   // ---------------- reference model ----------------
   logic              mValid [SETS][WAYS];
   logic [TAG_W-1:0]  mTag   [SETS][WAYS];
   logic [LINE_W-1:0] mLine  [SETS][WAYS];
   int                mStamp [SETS][WAYS];  // larger = more recently used
   int                tick;

   task automatic modelReset();
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < WAYS; w++) begin
            mValid[s][w] = 1'b0;
            mTag[s][w]   = '0;
            mLine[s][w]  = '0;
            mStamp[s][w] = -w;   // way 0 most recent, highest way least recent
         end
      end
      tick = 0;
      expQ.delete();
      evictQ.delete();
      memReqQ.delete();
   endtask

   task automatic modelAccess(input logic [ADDR_W-1:0] a);
      int s;
      int o;
      int w;
      logic [TAG_W-1:0]  t;
      logic [ADDR_W-1:0] la;
      s  = int'(a[7:5]);
      o  = int'(a[4:0]);
      t  = a[31:8];
      la = {a[31:5], 5'b0};
      w  = -1;
      for (int i = 0; i < WAYS; i++)
         if (w < 0 && mValid[s][i] && mTag[s][i] == t) w = i;
      if (w >= 0) begin
         expQ.push_back({1'b1, mLine[s][w][8*o +: 8]});
      end else begin
         memReqQ.push_back(la);
         for (int i = 0; i < WAYS; i++)
            if (w < 0 && !mValid[s][i]) w = i;
         if (w < 0) begin
            w = 0;
            for (int i = 1; i < WAYS; i++)
               if (mStamp[s][i] < mStamp[s][w]) w = i;
            evictQ.push_back({mTag[s][w], a[7:5], 5'b0, mLine[s][w]});
         end
         mValid[s][w] = 1'b1;
         mTag[s][w]   = t;
         mLine[s][w]  = memLine(la);
         expQ.push_back({1'b0, mLine[s][w][8*o +: 8]});
      end
      tick++;
      mStamp[s][w] = tick;
   endtask

   // ---------------- monitor / scoreboard ----------------
   logic [8:0]       popResp;
   logic [CMP_W-1:0] popEvict;
   logic [ADDR_W-1:0] popAddr;

   always @(negedge CLK) begin
      if (resp_valid) begin
         respCount++;
         if (expQ.size() == 0) begin
            nVec++;
            nFail++;
            $display("FAIL unexpected_resp: got hit=%0b data=%0h, required no response", hit, dataReturn);
         end else begin
            popResp = expQ.pop_front();
            check("resp_hit_data", CMP_W'({hit, dataReturn}), CMP_W'(popResp));
         end
      end
      if (evict_valid) begin
         evictCount++;
         if (evictQ.size() == 0) begin
            nVec++;
            nFail++;
            $display("FAIL unexpected_evict: got addr=%0h, required no eviction", evict_addr);
         end else begin
            popEvict = evictQ.pop_front();
            check("evict_addr_data", {evict_addr, toMemData}, popEvict);
         end
      end
      if (mem_req_valid && !prevMemReq) begin
         memReqCount++;
         lastMemReqAddr = mem_req_addr;
         if (memReqQ.size() == 0) begin
            nVec++;
            nFail++;
            $display("FAIL unexpected_mem_req: got addr=%0h, required no fetch", mem_req_addr);
         end else begin
            popAddr = memReqQ.pop_front();
            check("mem_req_addr", CMP_W'(mem_req_addr), CMP_W'(popAddr));
         end
      end
      prevMemReq = mem_req_valid;
   end

   // ---------------- memory responder ----------------
   initial begin
      int d;
      forever begin
         @(negedge CLK);
         if (mem_req_valid && !memHold) begin
            d = $urandom_range(0, 4);
            repeat (d) @(negedge CLK);
            if (mem_req_valid && !memHold) begin
               memData        = memLine(mem_req_addr);
               mem_resp_valid = 1'b1;
               @(negedge CLK);
               mem_resp_valid = 1'b0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic doRead(input logic [ADDR_W-1:0] a);
      int g;
      g = 0;
      while (!req_ready && g < 1000) begin
         @(negedge CLK);
         g++;
      end
      if (g >= 1000) begin
         nVec++;
         nFail++;
         $display("FAIL ready_timeout: got req_ready=0 for 1000 cycles, required 1");
      end else begin
         req_valid = 1'b1;
         req_addr  = a;
         modelAccess(a);
         @(negedge CLK);
         req_valid = 1'b0;
      end
   endtask

   task automatic waitIdle();
      int g;
      g = 0;
      while ((expQ.size() != 0 || !req_ready) && g < 1000) begin
         @(negedge CLK);
         g++;
      end
      if (g >= 1000) begin
         nVec++;
         nFail++;
         $display("FAIL idle_timeout: got %0d pending responses, required 0", expQ.size());
      end
      @(negedge CLK);
   endtask

   task automatic waitMemReq();
      int g;
      g = 0;
      while (!mem_req_valid && g < 100) begin
         @(negedge CLK);
         g++;
      end
      if (g >= 100) begin
         nVec++;
         nFail++;
         $display("FAIL mem_req_timeout: got mem_req_valid=0, required 1");
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int r0;
      int g;
      logic [ADDR_W-1:0] a;

      for (int h = 0; h < 16; h++) pattern[16*h +: 16] = {4{4'(h)}};
      modelReset();

      RST = 1'b1;
      repeat (3) @(negedge CLK);
      RST = 1'b0;

      check("rst_req_ready",     CMP_W'(req_ready),     CMP_W'(1));
      check("rst_resp_valid",    CMP_W'(resp_valid),    CMP_W'(0));
      check("rst_mem_req_valid", CMP_W'(mem_req_valid), CMP_W'(0));
      check("rst_evict_valid",   CMP_W'(evict_valid),   CMP_W'(0));
      check("rst_hit_data",      CMP_W'({hit, dataReturn}), CMP_W'(0));
      check("rst_addrs",         CMP_W'({mem_req_addr, evict_addr}), CMP_W'(0));
      check("rst_toMemData",     CMP_W'(toMemData),     CMP_W'(0));

      // 1: cold miss
      fixedLine = pattern;
      doRead(32'h0010_0001);
      waitIdle();
      check("t1_fetch_addr", CMP_W'(lastMemReqAddr), CMP_W'(32'h0010_0000));
      check("t1_hit_data",   CMP_W'({hit, dataReturn}), CMP_W'({1'b0, 8'h00}));
      check("t1_no_evict",   CMP_W'(evictCount), CMP_W'(0));

      // 2: hit, resp_valid on the second edge counting the accepting one
      doRead(32'h0010_0002);
      check("t2_resp_early", CMP_W'(resp_valid), CMP_W'(0));
      @(negedge CLK);
      check("t2_resp_latency", CMP_W'(resp_valid), CMP_W'(1));
      check("t2_hit_data",     CMP_W'({hit, dataReturn}), CMP_W'({1'b1, 8'h11}));
      waitIdle();
      check("t2_no_fetch", CMP_W'(memReqCount), CMP_W'(1));

      // 3: fill way 1, then evict the LRU way 0
      doRead(32'h0020_0002);
      doRead(32'h0030_0003);
      waitIdle();
      check("t3_evict_count", CMP_W'(evictCount), CMP_W'(1));
      check("t3_evict_addr",  CMP_W'(evict_addr), CMP_W'(32'h0010_0000));
      check("t3_evict_line",  CMP_W'(toMemData),  CMP_W'(pattern));
      check("t3_hit_data",    CMP_W'({hit, dataReturn}), CMP_W'({1'b0, 8'h11}));

      // 4: another set, then hits served from the array with memory zeroed
      doRead(32'h0230_00F3);
      waitIdle();
      check("t4_data",     CMP_W'({hit, dataReturn}), CMP_W'({1'b0, 8'h99}));
      check("t4_no_evict", CMP_W'(evictCount), CMP_W'(1));
      fixedLine = '0;
      doRead(32'h0030_0003);
      waitIdle();
      check("t4_hit_a", CMP_W'({hit, dataReturn}), CMP_W'({1'b1, 8'h11}));
      doRead(32'h0020_0002);
      waitIdle();
      check("t4_hit_b", CMP_W'({hit, dataReturn}), CMP_W'({1'b1, 8'h11}));

      // 5: reset while waiting on memory
      memHold = 1'b1;
      doRead(32'h0040_0000);
      waitMemReq();
      @(negedge CLK);
      r0 = respCount;
      RST = 1'b1;
      modelReset();
      @(negedge CLK);
      check("t5_mem_req_dropped", CMP_W'(mem_req_valid), CMP_W'(0));
      check("t5_ready",           CMP_W'(req_ready),     CMP_W'(1));
      check("t5_no_resp",         CMP_W'(resp_valid),    CMP_W'(0));
      RST = 1'b0;
      memHold = 1'b0;
      repeat (3) @(negedge CLK);
      check("t5_no_resp_count", CMP_W'(respCount - r0), CMP_W'(0));
      fixedLine = pattern;
      doRead(32'h0030_0003);
      waitIdle();
      check("t5_reread_miss", CMP_W'({hit, dataReturn}), CMP_W'({1'b0, 8'h11}));

      // 6: stray memory response in IDLE, then req_valid held through a miss
      r0 = respCount;
      memData        = {8{$urandom()}};
      mem_resp_valid = 1'b1;
      @(negedge CLK);
      mem_resp_valid = 1'b0;
      check("t6_idle_ready", CMP_W'({req_ready, mem_req_valid, resp_valid}), CMP_W'(3'b100));
      memHold   = 1'b1;
      req_valid = 1'b1;
      req_addr  = 32'h0050_0004;
      modelAccess(32'h0050_0004);
      waitMemReq();
      repeat (3) @(negedge CLK);
      memHold = 1'b0;
      g = 0;
      while (!resp_valid && g < 100) begin
         @(negedge CLK);
         g++;
      end
      req_valid = 1'b0;
      waitIdle();
      repeat (3) @(negedge CLK);
      check("t6_one_resp", CMP_W'(respCount - r0), CMP_W'(1));

      // randomized phase: few tags over few sets to force conflicts
      genMode = 1'b1;
      for (int n = 0; n < 300; n++) begin
         a = {20'h0, 4'($urandom_range(0, 5)), 3'($urandom_range(0, 2)),
              5'($urandom_range(0, 31))};
         repeat ($urandom_range(0, 2)) @(negedge CLK);
         doRead(a);
      end
      waitIdle();
      repeat (2) @(negedge CLK);
      check("final_resp_drained",  CMP_W'(expQ.size()),    CMP_W'(0));
      check("final_evict_drained", CMP_W'(evictQ.size()),  CMP_W'(0));
      check("final_fetch_drained", CMP_W'(memReqQ.size()), CMP_W'(0));

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion within time limit, required finish");
      $fatal(1, "watchdog expired");
   end

endmodule
